// File: rtl/viterbi_in_ctrl.sv
// -----------------------------------------------------------------------------
// viterbi_in_ctrl
//
// Input controller for a Viterbi decoder. It reads a frame of 16-bit
// received words from a word memory and streams each word out as eight
// 2-bit symbol pairs, MSB pair first, to the branch-metric unit. While one
// word is being shifted out, the next word is fetched into a one-entry
// prefetch buffer. This keeps the symbol stream gap-free when the consumer
// never stalls.
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   rst           asynchronous, active-high reset
//   i_start       one-cycle frame request; only looked at in IDLE
//   i_abort       synchronous frame cancel; returns to IDLE, no done pulse
//   i_base_addr   first word address of the frame (latched on start)
//   i_frame_len   number of words in the frame (latched on start)
//   o_mem_rd      word read strobe
//   o_mem_addr    read address, meaningful while o_mem_rd=1
//   i_mem_rdata   read data, valid exactly one cycle after o_mem_rd
//   o_sym_data    current symbol pair (shift_reg[15:14])
//   o_sym_valid   symbol pair available
//   i_sym_ready   consumer accepts the symbol pair
//   o_busy        high from the cycle after an accepted start until DONE exits
//   o_done        one-cycle completion pulse
//   o_sym_cnt     symbol pairs transferred in the current/last frame
//   o_state       FSM state, for observation only
//
// Symbol handshake: a pair transfers on a rising edge where o_sym_valid and
// i_sym_ready are both high. Once o_sym_valid is raised, o_sym_valid and
// o_sym_data hold steady until that transfer happens. The only exceptions
// are abort and reset, which withdraw the symbol.
// -----------------------------------------------------------------------------
module viterbi_in_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_frame_len,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [15:0]       i_mem_rdata,
    output logic [1:0]        o_sym_data,
    output logic              o_sym_valid,
    input  logic              i_sym_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W+3:0] o_sym_cnt,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W+3:0] CNT_ONE  = {{(ADDR_W+3){1'b0}}, 1'b1};
    localparam logic [2:0]        LAST_PAIR = 3'd7;

    // Control state
    state_t            r_state;
    logic [ADDR_W-1:0] r_next_addr;   // address of the next word to read
    logic [ADDR_W:0]   r_words_left;  // words of the frame not yet read
    logic [15:0]       r_shift;       // word currently being shifted out
    logic [2:0]        r_pair;        // index of the pair at r_shift[15:14]
    logic [15:0]       r_pf_buf;      // prefetched next word
    logic              r_pf_valid;    // r_pf_buf holds an unconsumed word
    logic              r_pf_cap;      // prefetch data arrives this cycle

    // Registered outputs
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_sym_valid;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W+3:0] r_sym_cnt;

    // Combinational helpers
    logic w_hs;          // symbol transfer on this edge
    logic w_last_pair;   // the pair on offer is the last of its word
    logic w_more_words;  // frame still has unread words
    logic w_word_end;    // pair 7 transfers on this edge
    logic w_pf_issue;    // start a prefetch read in the next cycle

    assign w_hs         = r_sym_valid & i_sym_ready;
    assign w_last_pair  = (r_pair == LAST_PAIR);
    assign w_more_words = (r_words_left != '0);
    assign w_word_end   = w_hs & w_last_pair;

    // At most one read is in flight, and the buffer holds only one word.
    // At the end of a word with an empty buffer, the FETCH path issues the
    // read instead, so prefetch stands aside in that case.
    assign w_pf_issue = (r_state == S_SHIFT) && w_more_words && !r_pf_valid &&
                        !r_mem_rd && !r_pf_cap && !w_word_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_next_addr  <= '0;
            r_words_left <= '0;
            r_shift      <= '0;
            r_pair       <= '0;
            r_pf_buf     <= '0;
            r_pf_valid   <= 1'b0;
            r_pf_cap     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_sym_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sym_cnt    <= '0;
        end else begin
            r_done <= 1'b0;

            // A transfer is counted even when abort arrives with it.
            if (w_hs) begin
                r_sym_cnt <= r_sym_cnt + CNT_ONE;
            end

            if (i_abort) begin
                r_state     <= S_IDLE;
                r_mem_rd    <= 1'b0;
                r_sym_valid <= 1'b0;
                r_pf_valid  <= 1'b0;
                r_pf_cap    <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_busy    <= 1'b1;
                            r_sym_cnt <= '0;
                            if (i_frame_len == '0) begin
                                // Empty frame: finish without touching memory.
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state      <= S_FETCH;
                                r_mem_rd     <= 1'b1;
                                r_mem_addr   <= i_base_addr;
                                r_next_addr  <= i_base_addr + ADDR_ONE;
                                r_words_left <= i_frame_len - LEN_ONE;
                            end
                        end
                    end

                    S_FETCH: begin
                        // The read strobe is high for this single cycle.
                        r_mem_rd <= 1'b0;
                        r_pf_cap <= 1'b0;
                        r_state  <= S_WAIT;
                    end

                    S_WAIT: begin
                        r_shift     <= i_mem_rdata;
                        r_pair      <= '0;
                        r_sym_valid <= 1'b1;
                        r_state     <= S_SHIFT;
                    end

                    S_SHIFT: begin
                        // Any read seen in SHIFT is a prefetch. Its data
                        // lands one cycle later.
                        r_pf_cap <= r_mem_rd;
                        if (r_pf_cap) begin
                            r_pf_buf   <= i_mem_rdata;
                            r_pf_valid <= 1'b1;
                        end

                        if (w_pf_issue) begin
                            r_mem_rd     <= 1'b1;
                            r_mem_addr   <= r_next_addr;
                            r_next_addr  <= r_next_addr + ADDR_ONE;
                            r_words_left <= r_words_left - LEN_ONE;
                        end else begin
                            r_mem_rd <= 1'b0;
                        end

                        if (w_hs) begin
                            if (w_last_pair) begin
                                if (r_pf_valid) begin
                                    // Next word is ready: no bubble.
                                    r_shift    <= r_pf_buf;
                                    r_pf_valid <= 1'b0;
                                    r_pair     <= '0;
                                end else if (w_more_words) begin
                                    r_sym_valid  <= 1'b0;
                                    r_state      <= S_FETCH;
                                    r_mem_rd     <= 1'b1;
                                    r_mem_addr   <= r_next_addr;
                                    r_next_addr  <= r_next_addr + ADDR_ONE;
                                    r_words_left <= r_words_left - LEN_ONE;
                                end else begin
                                    r_sym_valid <= 1'b0;
                                    r_state     <= S_DONE;
                                    r_done      <= 1'b1;
                                end
                            end else begin
                                r_shift <= {r_shift[13:0], 2'b00};
                                r_pair  <= r_pair + 3'd1;
                            end
                        end
                    end

                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_mem_rd    = r_mem_rd;
    assign o_mem_addr  = r_mem_addr;
    assign o_sym_data  = r_shift[15:14];
    assign o_sym_valid = r_sym_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_sym_cnt   = r_sym_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_viterbi_in_ctrl.sv
`timescale 1ns/1ps
module tb_viterbi_in_ctrl;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic [ADDR_W-1:0] i_base_addr = '0;
  logic [ADDR_W:0]   i_frame_len = '0;
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [15:0]       i_mem_rdata = '0;
  logic [1:0]        o_sym_data;
  logic              o_sym_valid;
  logic              i_sym_ready = 1'b0;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W+3:0] o_sym_cnt;
  logic [2:0]        o_state;

  viterbi_in_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_frame_len(i_frame_len),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
    .o_sym_data(o_sym_data), .o_sym_valid(o_sym_valid), .i_sym_ready(i_sym_ready),
    .o_busy(o_busy), .o_done(o_done), .o_sym_cnt(o_sym_cnt), .o_state(o_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [15:0] mem [DEPTH];
  // Data is only meaningful the cycle after a read; other cycles carry noise.
  always @(posedge clk) i_mem_rdata <= o_mem_rd ? mem[o_mem_addr] : 16'($urandom);

  // ---------------- ready driver ----------------
  int rmode    = 0;  // 0: always ready, 1: random, 2: 5-cycle stall on 4th pair
  int bp_left  = 0;
  int frame_hs = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: i_sym_ready = 1'b1;
      1: i_sym_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (frame_hs == 3 && bp_left > 0) begin
          i_sym_ready = 1'b0;
          bp_left--;
        end else begin
          i_sym_ready = 1'b1;
        end
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [1:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [1:0]        sym_log[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W+3:0] m_cnt = '0;
  bit                start_accept = 1'b0;
  bit                prev_hold = 1'b0;
  logic [1:0]        prev_data = '0;
  int n_rd = 0, n_valid = 0, n_done = 0;
  int first_rd_cyc = -1, first_valid_cyc = -1, last_valid_cyc = -1, done_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : compare
    bit hs;
    if (rst) begin
      m_cnt = '0;
      prev_hold = 1'b0;
    end else begin
      hs = o_sym_valid && i_sym_ready;
      check("sym_cnt", 32'(o_sym_cnt), 32'(m_cnt));
      if (prev_hold) begin
        check("hold_valid", 32'(o_sym_valid), 32'd1);
        check("hold_data", 32'(o_sym_data), 32'(prev_data));
      end
      if (o_mem_rd) begin
        rd_log.push_back(o_mem_addr);
        if (n_rd == 0) first_rd_cyc = cyc;
        n_rd++;
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_addr: unexpected read of %0d, expected none (cycle %0d)", o_mem_addr, cyc);
        end else begin
          check("mem_addr", 32'(o_mem_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (o_sym_valid) begin
        if (n_valid == 0) first_valid_cyc = cyc;
        last_valid_cyc = cyc;
        n_valid++;
      end
      if (hs) begin
        sym_log.push_back(o_sym_data);
        frame_hs++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sym_data: unexpected symbol %0d, expected none (cycle %0d)", o_sym_data, cyc);
        end else begin
          check("sym_data", 32'(o_sym_data), 32'(exp_q.pop_front()));
        end
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (i_start && start_accept) m_cnt = '0;
      if (hs) m_cnt = m_cnt + 1'b1;
      prev_hold = o_sym_valid && !i_sym_ready && !i_abort;
      prev_data = o_sym_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Builds the expected read addresses and symbol pairs from the frame
  // description alone: word k lives at (base+k) mod 2^ADDR_W, pairs MSB first.
  task automatic load_model(input logic [ADDR_W-1:0] base, input int len);
    exp_q.delete();
    exp_addr_q.delete();
    for (int w = 0; w < len; w++) begin
      logic [ADDR_W-1:0] a;
      int word;
      a = base + ADDR_W'(w);
      exp_addr_q.push_back(a);
      word = int'(mem[a]);
      for (int p = 0; p < 8; p++) exp_q.push_back(2'((word >> (14 - 2 * p)) % 4));
    end
    n_rd = 0; n_valid = 0; n_done = 0; frame_hs = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
    sym_log.delete();
    rd_log.delete();
  endtask

  // Entered and left at posedge+1.
  task automatic run_frame(input logic [ADDR_W-1:0] base, input int len, input int mode,
                           input int abort_off, input bit ign);
    int start_c;
    rmode = mode;
    bp_left = 5;
    load_model(base, len);
    i_start = 1'b1; start_accept = 1'b1;
    i_base_addr = base; i_frame_len = (ADDR_W+1)'(len);
    start_c = cyc;
    @(posedge clk); #1;
    i_start = 1'b0; start_accept = 1'b0;
    i_base_addr = ADDR_W'($urandom);
    i_frame_len = (ADDR_W+1)'($urandom_range(0, 2047));
    check("busy_after_start", 32'(o_busy), 32'd1);
    if (ign) begin
      // Must be ignored: DUT is in FETCH or DONE here.
      i_start = 1'b1;
      i_frame_len = (ADDR_W+1)'($urandom_range(1, 8));
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    if (abort_off > 0) begin
      while (cyc < start_c + abort_off) begin
        @(posedge clk); #1;
      end
      i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
      check("abort_state_idle", 32'(o_state), 32'd0);
      check("abort_valid_low", 32'(o_sym_valid), 32'd0);
      check("abort_rd_low", 32'(o_mem_rd), 32'd0);
      check("abort_busy_low", 32'(o_busy), 32'd0);
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      exp_q.delete();
      exp_addr_q.delete();
    end else begin
      for (int i = 0; i < 60 * len + 40 && n_done == 0; i++) begin
        @(posedge clk); #1;
      end
      if (n_done == 0) begin
        n_tests++; n_fail++;
        $display("FAIL frame_timeout: no done within budget, expected done (len %0d)", len);
      end
      repeat (2) begin
        @(posedge clk); #1;
      end
      check("done_pulses", 32'(n_done), 32'd1);
      check("sym_left", 32'(exp_q.size()), 32'd0);
      check("rd_left", 32'(exp_addr_q.size()), 32'd0);
      check("read_count", 32'(n_rd), 32'(len));
      check("final_cnt", 32'(o_sym_cnt), 32'(8 * len));
      check("busy_end", 32'(o_busy), 32'd0);
      if (mode == 0) begin
        check("valid_cycles", 32'(n_valid), 32'(8 * len));
        if (len == 0) begin
          check("t_done_empty", 32'(done_cyc), 32'(start_c + 1));
        end else begin
          check("t_first_rd", 32'(first_rd_cyc), 32'(start_c + 1));
          check("t_first_valid", 32'(first_valid_cyc), 32'(start_c + 3));
          check("t_last_valid", 32'(last_valid_cyc), 32'(start_c + 2 + 8 * len));
          check("t_done", 32'(done_cyc), 32'(start_c + 3 + 8 * len));
        end
      end
    end
  endtask

  task automatic reset_mid_frame();
    logic [ADDR_W-1:0] base;
    base = ADDR_W'($urandom);
    rmode = 0;
    load_model(base, 3);
    i_start = 1'b1; start_accept = 1'b1;
    i_base_addr = base; i_frame_len = 11'd3;
    @(posedge clk); #1;
    i_start = 1'b0; start_accept = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_state", 32'(o_state), 32'd0);
    check("rst_async_rd", 32'(o_mem_rd), 32'd0);
    check("rst_async_addr", 32'(o_mem_addr), 32'd0);
    check("rst_async_valid", 32'(o_sym_valid), 32'd0);
    check("rst_async_data", 32'(o_sym_data), 32'd0);
    check("rst_async_busy", 32'(o_busy), 32'd0);
    check("rst_async_done", 32'(o_done), 32'd0);
    check("rst_async_cnt", 32'(o_sym_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rst_no_done", 32'(n_done), 32'd0);
    check("rst_idle", 32'(o_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [1:0]        lit_sym [8];
    logic [ADDR_W-1:0] lit_rd [3];
    lit_sym = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0};
    lit_rd  = '{10'd1022, 10'd1023, 10'd0};
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    mem[5] = 16'b1011000111100100;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(o_state), 32'd0);
    check("reset_rd", 32'(o_mem_rd), 32'd0);
    check("reset_valid", 32'(o_sym_valid), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_cnt", 32'(o_sym_cnt), 32'd0);
    check("reset_data", 32'(o_sym_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single known word: exact pair order.
    run_frame(10'd5, 1, 0, 0, 1'b0);
    check("lit_sym_count", 32'(sym_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < sym_log.size(); i++) check("lit_sym", 32'(sym_log[i]), 32'(lit_sym[i]));

    // Address wrap across the top of memory.
    run_frame(10'd1022, 3, 0, 0, 1'b0);
    check("lit_rd_count", 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++) check("lit_rd", 32'(rd_log[i]), 32'(lit_rd[i]));

    // Backpressure on the 4th pair.
    run_frame(10'd300, 1, 2, 0, 1'b0);
    run_frame(10'd301, 2, 2, 0, 1'b0);

    // Empty frame with a start pulse while busy.
    run_frame(10'd7, 0, 0, 0, 1'b1);

    // Abort in cycle 6 of a 2-word frame, then a clean rerun.
    run_frame(10'd100, 2, 0, 6, 1'b0);
    run_frame(10'd100, 2, 0, 0, 1'b0);

    reset_mid_frame();

    for (int f = 0; f < 40; f++) begin
      int len, mode, aoff;
      bit ign;
      len  = $urandom_range(0, 5);
      mode = $urandom_range(0, 2);
      ign  = ($urandom_range(0, 2) == 0);
      aoff = 0;
      if (len > 0 && $urandom_range(0, 4) == 0) aoff = $urandom_range(2, 2 + 8 * len);
      run_frame(ADDR_W'($urandom), len, mode, aoff, ign);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/viterbi_in_ctrl.md
VITERBI_IN_CTRL -- requirements
Module: viterbi_in_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, width of the word-memory address and frame-length fields.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a frame; sampled only in IDLE.
REQ-005 abort  input  1  synchronous frame cancel; returns to IDLE without done.
REQ-006 base_addr  input  ADDR_W  first word address of the frame, latched on accepted start.
REQ-007 frame_len  input  ADDR_W+1  number of 16-bit words in the frame, latched on accepted start.
REQ-008 mem_rd  output  1  word read strobe to the received-data memory.
REQ-009 mem_addr  output  ADDR_W  read address, valid while mem_rd=1.
REQ-010 mem_rdata  input  16  read data, valid exactly one cycle after mem_rd.
REQ-011 sym_data  output  2  current received symbol pair for the branch-metric unit.
REQ-012 sym_valid / sym_ready  output 1 / input 1  symbol handshake; transfer when both high on a rising edge.
REQ-013 busy  output  1  high from the cycle after an accepted start until DONE exits.
REQ-014 done  output  1  one-cycle pulse on frame completion.
REQ-015 sym_cnt  output  ADDR_W+4  symbols transferred in the current frame.

Function
REQ-016 States SHALL be IDLE, FETCH, WAIT, SHIFT, DONE.
REQ-017 IDLE: start=1 with frame_len!=0 -> latch base_addr and frame_len, clear sym_cnt -> FETCH.
REQ-018 IDLE: start=1 with frame_len=0 -> DONE directly; no mem_rd issued.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 FETCH: mem_rd=1 for exactly one cycle at the current word address -> WAIT.
REQ-021 WAIT: capture mem_rdata into the 16-bit shift register, clear pair index -> SHIFT.
REQ-022 SHIFT: sym_valid=1, sym_data=shift_reg[15:14]; MSB pair first, 8 pairs per word.
REQ-023 On handshake: shift left by 2, pair index +1, sym_cnt +1; no change without handshake.
REQ-024 sym_data SHALL remain stable while sym_valid=1 and sym_ready=0.
REQ-025 Prefetch: in SHIFT, if a further word remains, the prefetch buffer is empty and no read is outstanding, issue mem_rd for the next address; capture into the prefetch buffer next cycle.
REQ-026 On the handshake of pair 7: last word -> DONE; prefetch buffer full -> load it into the shift register and stay in SHIFT with no bubble; otherwise -> FETCH.
REQ-027 With sym_ready held high, an N-word frame SHALL yield 8N consecutive sym_valid cycles.
REQ-028 Latency: start in cycle 0 -> mem_rd in cycle 1 -> first sym_valid in cycle 3.
REQ-029 Word address SHALL advance base_addr, base_addr+1, ...; it wraps modulo 2^ADDR_W.
REQ-030 DONE: done=1 for one cycle -> IDLE; sym_cnt holds its final value until the next accepted start.
REQ-031 abort=1 in any state: next state IDLE; sym_valid and mem_rd drop in that cycle; prefetch buffer cleared; no done.
REQ-032 A handshake in the same cycle as abort SHALL count (sym_cnt +1); abort takes precedence over the state transition.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and set mem_rd, sym_valid, busy and done to 0.
REQ-034 rst=1 SHALL also clear sym_data, mem_addr, sym_cnt, the shift register and the prefetch valid flag.
REQ-035 rst asserted mid-frame discards the frame; no done is produced.

Verification
REQ-036 Reset check: assert rst asynchronously between edges -> all outputs 0 before the next edge; state IDLE.
REQ-037 Single word: frame_len=1, word 16'b1011000111100100, sym_ready=1 -> sym_data 10,11,00,01,11,10,01,00 in cycles 3..10, done in cycle 11, sym_cnt=8.
REQ-038 Three words, base_addr=1022, ADDR_W=10 -> mem_rd at 1022, 1023, 0 only; 24 contiguous sym_valid; sym_cnt=24.
REQ-039 Backpressure: sym_ready=0 for 5 cycles on the 4th pair -> sym_data held; all 8 pairs delivered in order; no duplicate mem_rd.
REQ-040 frame_len=0 -> done pulse in cycle 1; no mem_rd, no sym_valid; start pulses while busy are ignored.
REQ-041 abort in cycle 6 of a 2-word frame -> IDLE in cycle 7; no done; a new start then runs normally from base_addr.
